// File: rtl/mul_op_sequencer_if.sv
// Bus bundle for mul_op_sequencer: operand input, multiplier side,
// result output and status. The sequencer uses the slave modport;
// whatever sits around it (datapath, multiplier, bench) uses master.
interface mul_op_sequencer_if #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = NUM_INPUTS * DATA_WIDTH;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [DATA_WIDTH-1:0]                 in_data [NUM_INPUTS];
  logic                                  mul_en;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] mul_data;
  logic                                  mul_done;
  logic [RW-1:0]                         mul_result;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [RW-1:0]                         out_data;
  logic                                  out_timeout;
  logic [CW-1:0]                         fifo_count;
  logic                                  busy;

  modport slave (
    input  in_valid, in_data, mul_done, mul_result, out_ready,
    output in_ready, mul_en, mul_data, out_valid, out_data, out_timeout,
           fifo_count, busy
  );

  modport master (
    output in_valid, in_data, mul_done, mul_result, out_ready,
    input  in_ready, mul_en, mul_data, out_valid, out_data, out_timeout,
           fifo_count, busy
  );
endinterface

// File: rtl/mul_op_sequencer.sv
// Operand FIFO + single-issue sequencer in front of a variable-latency
// stochastic multiplier. Each popped vector yields exactly one result,
// either the product or a watchdog timeout marker, in arrival order.
module mul_op_sequencer #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2048
) (
  input logic              clk,
  input logic              rst,
  mul_op_sequencer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = NUM_INPUTS * DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT - 1);

  typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  vec_t          mem [FIFO_DEPTH];
  vec_t          in_vec;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic          full, push, pop, timeout_hit;

  // Flatten the unpacked operand port into one FIFO word.
  always_comb begin
    in_vec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) in_vec[i] = bus.in_data[i];
  end

  assign full        = (count == DEPTH_C);
  assign push        = bus.in_valid && !full;
  // Pop only from IDLE on the registered count, so a word written this
  // cycle into an empty FIFO is not visible until the next one.
  assign pop         = (state == IDLE) && (count != '0);
  assign timeout_hit = (timer == TMAX_C);

  assign bus.in_ready   = !full;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != IDLE);

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_vec;
  end

  // FIFO pointers and occupancy; pointers wrap on the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: done beats the watchdog when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = RUN;
      RUN:     if (bus.mul_done || timeout_hit) state_nxt = DRAIN;
      DRAIN:   if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue/collect datapath: operands held for the whole op, result held
  // until the consumer takes it; mul_done is only looked at in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mul_en      <= 1'b0;
      bus.mul_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_timeout <= 1'b0;
      timer           <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          bus.mul_data <= mem[rd_ptr];
          bus.mul_en   <= 1'b1;
          timer        <= '0;
        end
        RUN: begin
          if (bus.mul_done) begin
            bus.out_data    <= bus.mul_result;
            bus.out_timeout <= 1'b0;
            bus.out_valid   <= 1'b1;
            bus.mul_en      <= 1'b0;
          end else if (timeout_hit) begin
            bus.out_data    <= '0;
            bus.out_timeout <= 1'b1;
            bus.out_valid   <= 1'b1;
            bus.mul_en      <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DRAIN: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  logic [RW-1:0] unused_rw;
  assign unused_rw = '0;
endmodule

// File: tb/tb_mul_op_sequencer.sv
// Bench for mul_op_sequencer: a behavioural multiplier that answers after a
// per-operation latency, a scoreboard of expected results in push order,
// and cycle-level checks of FIFO occupancy, handshake stability and reset.
module tb_mul_op_sequencer;
  localparam int DW = 5;
  localparam int NI = 2;
  localparam int FD = 4;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            lat;       // cycles of mul_en before done; 0 = never
    int            exp_data;
    bit            exp_to;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_op_sequencer_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .FIFO_DEPTH(FD)) bus ();

  mul_op_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  vec_cnt = 0;
  int  err_cnt = 0;
  op_t iss_q[$];
  op_t exp_q[$];
  int  n_pushed  = 0;
  int  n_started = 0;
  bit  spurious  = 1'b0;

  // monitor / multiplier model state
  op_t           cur;
  int            cnt = 0;
  bit            hold_v = 1'b0;
  logic [63:0]   hold_d;
  logic          hold_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic int dur_of(input int lat);
    return (lat != 0 && lat <= TO) ? lat : TO;
  endfunction

  // Reference expectation: product if the multiplier answers within the
  // watchdog window (answering on the last cycle still counts), else marker.
  function automatic op_t mk_op(input int a, input int b, input int lat);
    op_t o;
    o.a = DW'(a);
    o.b = DW'(b);
    o.lat = lat;
    o.exp_to = !(lat != 0 && lat <= TO);
    o.exp_data = o.exp_to ? 0 : a * b;
    return o;
  endfunction

  // Multiplier model plus output/occupancy checks, once per cycle on the
  // falling edge.
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0;
      hold_v = 1'b0;
      bus.mul_done = 1'b0;
    end else begin
      if (bus.mul_en) begin
        if (cnt == 0) begin
          if (iss_q.size() == 0) fail_now("unexpected_issue");
          else begin
            cur = iss_q.pop_front();
            n_started++;
            chk("issue_mul_data", 64'(bus.mul_data), 64'({cur.b, cur.a}));
            bus.mul_result = 10'(int'(cur.a) * int'(cur.b));
          end
        end else begin
          chk("mul_data_stable", 64'(bus.mul_data), 64'({cur.b, cur.a}));
        end
        cnt++;
        bus.mul_done = (cnt == cur.lat);
      end else begin
        if (cnt != 0) chk("mul_en_cycles", 64'(cnt), 64'(dur_of(cur.lat)));
        cnt = 0;
        bus.mul_done = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        if (spurious) bus.mul_result = 10'($urandom);
      end
      chk("fifo_count", 64'(bus.fifo_count), 64'(n_pushed - n_started));
      chk("in_ready", 64'(bus.in_ready), 64'((n_pushed - n_started) != FD));
      if (bus.out_valid) chk("mul_en_low_while_out_valid", 64'(bus.mul_en), 64'(0));
      if (hold_v) begin
        chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_out_data", 64'(bus.out_data), hold_d);
        chk("hold_out_timeout", 64'(bus.out_timeout), 64'(hold_t));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else begin
          op_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.exp_data));
          chk("out_timeout", 64'(bus.out_timeout), 64'(e.exp_to));
        end
        hold_v = 1'b0;
      end else if (bus.out_valid) begin
        hold_v = 1'b1;
        hold_d = 64'(bus.out_data);
        hold_t = bus.out_timeout;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Present one vector and hold it until the FIFO takes it. Called a little
  // after a rising edge.
  task automatic push(input op_t o);
    int guard = 0;
    bus.in_data[0] = o.a;
    bus.in_data[1] = o.b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      guard++;
      if (guard > 400) begin
        fail_now("push_wait_bound");
        break;
      end
    end
    @(posedge clk);
    n_pushed++;
    iss_q.push_back(o);
    exp_q.push_back(o);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 || iss_q.size() != 0 || bus.busy) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        fail_now("drain_wait_bound");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mul_en"}, 64'(bus.mul_en), 64'(0));
    chk({tag, "_mul_data"}, 64'(bus.mul_data), 64'(0));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(bus.out_data), 64'(0));
    chk({tag, "_out_timeout"}, 64'(bus.out_timeout), 64'(0));
    chk({tag, "_fifo_count"}, 64'(bus.fifo_count), 64'(0));
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    op_t tbl [8];
    bit  rnd_done;
    int  guard;

    tbl[0] = '{5'd3,  5'd7,  11, 21,  1'b0};  // basic op
    tbl[1] = '{5'd31, 5'd31, 1,  961, 1'b0};  // max operands, fastest answer
    tbl[2] = '{5'd2,  5'd2,  0,  0,   1'b1};  // never answers -> timeout
    tbl[3] = '{5'd5,  5'd6,  16, 30,  1'b0};  // done on the timeout cycle
    tbl[4] = '{5'd1,  5'd1,  17, 0,   1'b1};  // one cycle too late
    tbl[5] = '{5'd0,  5'd9,  3,  0,   1'b0};  // zero product, not a timeout
    tbl[6] = '{5'd4,  5'd8,  15, 32,  1'b0};
    tbl[7] = '{5'd31, 5'd1,  2,  31,  1'b0};

    bus.in_valid = 1'b0;
    bus.in_data[0] = '0;
    bus.in_data[1] = '0;
    bus.out_ready = 1'b0;
    bus.mul_done = 1'b0;
    bus.mul_result = '0;

    #1 check_reset_vals("reset");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // table-driven single operations
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(tbl[i]);
      wait_drain();
    end

    // fill the FIFO behind a stalled result, then release; the sixth push
    // waits through the pop cycle where in_ready is still low
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(mk_op(k, k, 2));
    repeat (3) @(negedge clk);
    chk("fill_fifo_count", 64'(bus.fifo_count), 64'(4));
    chk("fill_in_ready", 64'(bus.in_ready), 64'(0));
    chk("fill_out_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk);
    #1;
    fork
      push(mk_op(6, 6, 2));
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // backpressure with spurious done pulses while the result is parked
    bus.out_ready = 1'b0;
    push(mk_op(9, 3, 4));
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_out_valid_seen", 64'(bus.out_valid), 64'(1));
    spurious = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_still_valid", 64'(bus.out_valid), 64'(1));
    chk("bp_mul_en", 64'(bus.mul_en), 64'(0));
    spurious = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain();

    // randomized traffic with random backpressure and spurious done
    spurious = 1'b1;
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int r, lat;
          r = int'($urandom_range(0, 9));
          case (r)
            0: lat = 0;
            1: lat = TO;
            2: lat = TO + 1;
            default: lat = int'($urandom_range(1, TO - 1));
          endcase
          push(mk_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), lat));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    spurious = 1'b0;

    // reset in the middle of an operation with three entries queued
    for (int k = 0; k < 4; k++) push(mk_op(k + 2, 3, 0));
    @(negedge clk);
    chk("pre_rst_fifo_count", 64'(bus.fifo_count), 64'(3));
    chk("pre_rst_mul_en", 64'(bus.mul_en), 64'(1));
    #2 rst = 1'b1;
    #1 check_reset_vals("midrun_reset");
    iss_q.delete();
    exp_q.delete();
    n_pushed = 0;
    n_started = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("post_rst_mul_en", 64'(bus.mul_en), 64'(0));
    end
    @(posedge clk);
    #1;
    push(mk_op(7, 7, 5));
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
